// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice sequenced over WIDTH cycles.
// Optional subtract mode (port `sub`) is enabled by defining SERIAL_ADD_SUB_EN.

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sr_r, a_sr_s;
  logic [WIDTH-1:0] b_sr_r, b_sr_s;
  logic [WIDTH-1:0] sum_sr_r, sum_sr_s;
  logic             carry_r, carry_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] b_cap_s;
  logic             carry_cap_s;

  fa u_fa (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Operand/carry values loaded on an accepted start (subtract = a + ~b + 1)
  always_comb begin
    b_cap_s     = b;
    carry_cap_s = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_cap_s     = ~b;
      carry_cap_s = 1'b1;
    end else begin
      b_cap_s     = b;
      carry_cap_s = cin;
    end
`endif
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_s  = state_r;
    a_sr_s   = a_sr_r;
    b_sr_s   = b_sr_r;
    sum_sr_s = sum_sr_r;
    carry_s  = carry_r;
    cnt_s    = cnt_r;
    sum_s    = sum_r;
    cout_s   = cout_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_sr_s   = a;
          b_sr_s   = b_cap_s;
          carry_s  = carry_cap_s;
          cnt_s    = '0;
          sum_sr_s = '0;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sr_s   = {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_s   = {1'b0, b_sr_r[WIDTH-1:1]};
        sum_sr_s = {fa_sum_s, sum_sr_r[WIDTH-1:1]};
        carry_s  = fa_cout_s;
        cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // Last bit: publish the completed word, never a partial one
        if (cnt_r == LAST_BIT) begin
          state_s = ST_DONE;
          sum_s   = {fa_sum_s, sum_sr_r[WIDTH-1:1]};
          cout_s  = fa_cout_s;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      sum_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
    end else begin
      a_sr_r   <= a_sr_s;
      b_sr_r   <= b_sr_s;
      sum_sr_r <= sum_sr_s;
      carry_r  <= carry_s;
      cnt_r    <= cnt_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      sum_r    <= sum_s;
      cout_r   <= cout_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// 1-bit full adder slice shared by the serial controller.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 directed + random, WIDTH=16 random.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADD_SUB_EN
  logic sub8, sub16;
`endif

  int checks = 0;
  int failures = 0;
  int done8_cnt = 0;
  longint q8[$];
  longint q16[$];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {cout,sum} from plain integer arithmetic
  function automatic longint model(input int w, input longint a, input longint b,
                                   input bit c, input bit s);
    longint m;
    m = (longint'(1) << w) - 1;
    if (s) return ((a - b) & m) | ((a >= b) ? (longint'(1) << w) : 64'd0);
    return a + b + longint'(c);
  endfunction

  // Monitors: pop expected result on every done strobe
  always @(negedge clk) begin
    if (!rst && done8) begin
      done8_cnt++;
      chk("busy_with_done8", longint'(busy8), 0);
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("result8", longint'({cout8, sum8}), q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done16) begin
      chk("busy_with_done16", longint'(busy16), 0);
      if (q16.size() == 0) chk("unexpected_done16", 1, 0);
      else chk("result16", longint'({cout16, sum16}), q16.pop_front());
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input longint exp);
    int n = 0;
    while ((busy8 || done8) && n < 100) begin @(posedge clk); #1; n++; end
    a8 = a; b8 = b; cin8 = c;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = s;
`endif
    q8.push_back(exp);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'hxx; b8 = 8'hxx; cin8 = 1'bx;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic s, input longint exp);
    int n = 0;
    while ((busy16 || done16) && n < 100) begin @(posedge clk); #1; n++; end
    a16 = a; b16 = b; cin16 = c;
`ifdef SERIAL_ADD_SUB_EN
    sub16 = s;
`endif
    q16.push_back(exp);
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || busy8 || done8) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain8", longint'(q8.size()), 0);
  endtask

  initial begin
    int n, first, second;
    int c0;
    logic prev;
    bit rs;
    logic [7:0] ra8, rb8;
    logic [15:0] ra16, rb16;
    logic rc;

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b0; sub16 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", longint'(busy8), 0);
    chk("reset_done", longint'(done8), 0);
    chk("reset_sum", longint'(sum8), 0);
    chk("reset_cout", longint'(cout8), 0);

    // 1+1: done exactly 9 cycles after start is raised
    a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(64'h002);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start8 = 1'b0;
        chk("busy_after_accept", longint'(busy8), 1);
      end
    end while (!done8 && n < 50);
    chk("latency", n, 9);
    drain8();

    op8(8'hFF, 8'h01, 1'b0, 1'b0, 64'h100);
    op8(8'hAA, 8'h55, 1'b1, 1'b0, 64'h100);
    op8(8'hAA, 8'h55, 1'b0, 1'b0, 64'h0FF);
    drain8();
    chk("hold_sum_after_done", longint'(sum8), 64'hFF);

    // Starts during RUN and DONE are ignored
    c0 = done8_cnt;
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b0;
`endif
    q8.push_back(64'h007);
    start8 = 1'b1;
    for (int m = 0; m < 16; m++) begin
      @(posedge clk); #1;
      start8 = (m == 2 || m == 8) ? 1'b1 : 1'b0;
      if (m == 2) begin a8 = 8'hFF; b8 = 8'hFF; end
    end
    chk("single_done", done8_cnt - c0, 1);
    chk("ignored_start_sum", longint'(sum8), 64'h07);
    drain8();

    // Continuous start: accepted every WIDTH+2 cycles
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back(64'h046);
    q8.push_back(64'h046);
    start8 = 1'b1;
    first = -1; second = -1; prev = 1'b0;
    for (int m = 1; m <= 40 && second < 0; m++) begin
      @(posedge clk); #1;
      if (busy8 && !prev) begin
        if (first < 0) first = m;
        else begin second = m; start8 = 1'b0; end
      end
      prev = busy8;
    end
    start8 = 1'b0;
    chk("hold_spacing", second - first, 10);
    drain8();

    // Reset 4 cycles into RUN aborts the operation
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", longint'(busy8), 0);
    chk("abort_done", longint'(done8), 0);
    chk("abort_sum", longint'(sum8), 0);
    chk("abort_cout", longint'(cout8), 0);
    repeat (12) @(posedge clk);
    #1;
    op8(8'h10, 8'h20, 1'b0, 1'b0, 64'h030);
    drain8();

`ifdef SERIAL_ADD_SUB_EN
    op8(8'd5, 8'd7, 1'b0, 1'b1, 64'h0FE);
    op8(8'd7, 8'd5, 1'b0, 1'b1, 64'h102);
    op8(8'd7, 8'd5, 1'b1, 1'b0, 64'h00D);
    drain8();
`endif

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom_range(0, 1));
          rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
          rs = 1'($urandom_range(0, 1));
`endif
          op8(ra8, rb8, rc, rs, model(8, longint'(ra8), longint'(rb8), rc, rs));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          ra16 = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom_range(0, 1));
          rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
          rs = 1'($urandom_range(0, 1));
`endif
          op16(ra16, rb16, rc, rs, model(16, longint'(ra16), longint'(rb16), rc, rs));
        end
      end
    join

    drain8();
    n = 0;
    while ((q16.size() != 0 || busy16 || done16) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain16", longint'(q16.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
